block_dev_ram: RTL
==================

Name: block_dev_ram

Overview:
- Synthesizable, RAM-backed block device. Serves the same bd_* command/handshake interface the disk controller already drives, so the controller can be tested and run on FPGA without a host-side model.
- Storage is a sector-organised internal memory. Sector count, sector size and seek latency are set by parameters.
- Adds explicit address-range and illegal-command error reporting, and a per-word IORDY handshake with a read prefetch pipeline.

Parameters:
- ADDR_BITS, 8, log2 of sector count. Sectors = 2**ADDR_BITS; valid bd_addr range is 0..2**ADDR_BITS-1.
- WORD_BITS, 8, log2 of 16-bit words per sector. Default 256 words = 512 bytes.
- SEEK_CYCLES, 4, idle cycles between command accept and first transfer. 0 is legal.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- bd_cmd  input  2  0=RESET, 1=READ, 2=WRITE, 3=illegal
- bd_start  input  1  command strobe, sampled in IDLE only
- bd_bsy  output  1  command in progress
- bd_rdy  output  1  device idle, ready for command
- bd_err  output  1  last command failed; sticky until next accepted bd_start
- bd_addr  input  24  sector number
- bd_data_in  input  16  write data
- bd_data_out  output  16  read data, valid while bd_iordy=1 in READ
- bd_rd  input  1  read-word acknowledge
- bd_wr  input  1  write-word strobe
- bd_iordy  output  1  word transfer may occur this cycle

Behaviour:
- Reset values: bd_bsy=0, bd_rdy=1, bd_err=0, bd_iordy=0, bd_data_out=0. FSM goes to IDLE; word pointer=0; seek counter=0. Memory contents are retained, not cleared.
- Reset asserted mid-command aborts the command immediately. Words already written stay written.
- States: IDLE, SEEK, FETCH, XFER.
- IDLE:
  - bd_start=1 at edge T: latch bd_cmd and bd_addr[ADDR_BITS-1:0]; clear the pointer.
  - Error check: cmd=3, or any of bd_addr[23:ADDR_BITS] set, gives bd_err=1 after T. State stays IDLE, bd_rdy stays 1, bd_bsy stays 0.
  - RESET command: bd_bsy=1, bd_rdy=0 for exactly one cycle, then back to IDLE with bd_err=0. No memory access.
  - READ/WRITE: after T, bd_bsy=1, bd_rdy=0, bd_err=0. Go to SEEK with counter=SEEK_CYCLES.
- SEEK:
  - Decrement the counter each cycle.
  - At 0, go to FETCH (READ) or XFER (WRITE).
  - With SEEK_CYCLES=0, SEEK lasts exactly one cycle.
- FETCH (READ only):
  - One cycle with synchronous memory read of mem[{sector,ptr}], bd_iordy=0.
  - Next state XFER; bd_data_out registered with the fetched word.
- XFER:
  - bd_iordy=1.
  - READ: bd_rd=1 at an edge advances ptr. If ptr was the last word (2**WORD_BITS-1), finish; otherwise go to FETCH. Steady throughput is one word per 2 cycles. bd_data_out holds its value until the next fetch completes.
  - WRITE: bd_wr=1 at an edge writes bd_data_in to mem[{sector,ptr}] and advances ptr. bd_iordy stays 1 between words, so back-to-back bd_wr gives one word per cycle. The last word finishes the command.
  - Finish: after that edge, bd_iordy=0, bd_bsy=0, bd_rdy=1; state IDLE.
  - bd_rd during WRITE and bd_wr during READ are ignored. If both are asserted, only the strobe matching the command is honoured.
  - Strobes while bd_iordy=0 (SEEK, FETCH, IDLE) are ignored.
- bd_start while bd_bsy=1 is ignored. No abort other than reset.
- Address arithmetic: the memory index is the concatenation {sector[ADDR_BITS-1:0], ptr[WORD_BITS-1:0]}. There is no carry into the next sector; ptr wraps only at command end.
- bd_rdy and bd_bsy are never both 1. bd_iordy=1 implies bd_bsy=1.
- Latency from the bd_start edge T:
  - WRITE: bd_iordy rises after edge T+SEEK_CYCLES+1.
  - READ: bd_iordy rises after edge T+SEEK_CYCLES+2.

Test Plan:
- Write then read back: params 8/8/4. WRITE sector 5 with data = 16'hA500 + word index, bd_wr held continuously. Expect bd_iordy high 5 cycles after start, 256 consecutive write cycles, then bd_bsy=0, bd_rdy=1. READ sector 5 with bd_rd asserted whenever bd_iordy=1: bd_data_out returns 16'hA500..16'hA5FF in order, bd_iordy toggling 1/0.
- Range and command errors: bd_addr=24'h000100 with ADDR_BITS=8 → bd_err=1 next cycle, bd_bsy never asserts. bd_cmd=3 → bd_err=1. A following valid READ of sector 0 clears bd_err on accept.
- RESET command: bd_cmd=0 with bd_start → bd_bsy=1 for exactly one cycle, bd_err cleared, sector 5 contents unchanged on re-read.
- Sector isolation and wrap: write sector 255 with all 16'hFFFF, then read sector 0 → previously written sector-0 data intact. Read sector 255 → all 16'hFFFF.
- Reset mid-write: assert reset after word 10 of a WRITE to sector 7 → all outputs at reset values asynchronously. Read sector 7 afterwards → words 0..9 new, words 10..255 old.
- Ignored strobes: bd_start pulses during an active READ, bd_wr during READ, and bd_rd during SEEK/FETCH → no state, pointer or memory change; the read completes with correct data.

Source files
------------

// File: rtl/block_dev_ram.sv
// RAM-backed block device serving the bd_* command/handshake interface.
// Sector-organised storage with seek delay, read prefetch and per-word IORDY.
module block_dev_ram #(
    parameter int ADDR_BITS   = 8,
    parameter int WORD_BITS   = 8,
    parameter int SEEK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bd_cmd,
    input  logic        bd_start,
    output logic        bd_bsy,
    output logic        bd_rdy,
    output logic        bd_err,
    input  logic [23:0] bd_addr,
    input  logic [15:0] bd_data_in,
    output logic [15:0] bd_data_out,
    input  logic        bd_rd,
    input  logic        bd_wr,
    output logic        bd_iordy
);

    localparam int DEPTH = 1 << (ADDR_BITS + WORD_BITS);
    localparam int CNT_W = (SEEK_CYCLES < 2) ? 1 : $clog2(SEEK_CYCLES + 1);
    localparam logic [CNT_W-1:0] SEEK_LOAD = CNT_W'(SEEK_CYCLES);

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_ILL   = 2'd3;

    typedef enum logic [1:0] {IDLE, SEEK, FETCH, XFER} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]   sector_q, sector_d;
    logic [WORD_BITS-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   rstcmd_q, rstcmd_d;
    logic [15:0]            dout_q;
    logic                   mem_we;
    logic                   dout_load;
    logic                   addr_bad;

    logic [15:0] mem [DEPTH];

    wire [ADDR_BITS+WORD_BITS-1:0] idx = {sector_q, ptr_q};

    assign addr_bad    = (bd_addr >> ADDR_BITS) != 24'd0;
    assign bd_iordy    = (state_q == XFER);
    assign bd_bsy      = (state_q != IDLE) || rstcmd_q;
    assign bd_rdy      = !bd_bsy;
    assign bd_err      = err_q;
    assign bd_data_out = dout_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        sector_d  = sector_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rstcmd_d  = 1'b0;
        mem_we    = 1'b0;
        dout_load = 1'b0;
        case (state_q)
            IDLE: begin
                // rstcmd_q marks the one busy cycle of a RESET command
                if (bd_start && !rstcmd_q) begin
                    cmd_d    = bd_cmd;
                    sector_d = bd_addr[ADDR_BITS-1:0];
                    ptr_d    = '0;
                    if (bd_cmd == CMD_ILL || addr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (bd_cmd == CMD_RESET) begin
                            rstcmd_d = 1'b1;
                        end else begin
                            state_d = SEEK;
                            cnt_d   = SEEK_LOAD;
                        end
                    end
                end
            end
            SEEK: begin
                if (cnt_q == '0) state_d = (cmd_q == CMD_READ) ? FETCH : XFER;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FETCH: begin
                dout_load = 1'b1;
                state_d   = XFER;
            end
            XFER: begin
                if (cmd_q == CMD_READ) begin
                    if (bd_rd) begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = (ptr_q == '1) ? IDLE : FETCH;
                    end
                end else if (bd_wr) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == '1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= CMD_RESET;
            sector_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rstcmd_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            sector_q <= sector_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rstcmd_q <= rstcmd_d;
            if (dout_load) dout_q <= mem[idx];
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= bd_data_in;
    end

endmodule
